// File: rtl/ch375_dev_uart_if.sv
// ch375_dev_uart_if: SoC register bus between a bus master and the CH375 device model.
//   a    master->slave  3   register address
//   d    master->slave  32  write data, byte lane d[31:24]
//   we   master->slave  1   write strobe, one access per cycle
//   spo  slave->master  32  combinational read data for address a
//   irq  slave->master  1   one-cycle pulse per frame pushed into the RX FIFO
interface ch375_dev_uart_if;
   logic [2:0]  a;
   logic [31:0] d;
   logic        we;
   logic [31:0] spo;
   logic        irq;

   modport master (output a, d, we, input spo, irq);
   modport slave  (input a, d, we, output spo, irq);
endinterface

// File: rtl/ch375_dev_uart.sv
// ch375_dev_uart: device-side endpoint of the CH375 9-bit serial link.
//   Receives 11-bit frames (start, 8 data LSB-first, cmd/data flag, stop) into a
//   tagged RX FIFO, transmits response bytes and drives the host interrupt line.
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   bus       register bus (slave modport): a, d, we in; spo, irq out
//   dev_tx    serial out to host rx, idle high
//   dev_rx    serial in from host tx, asynchronous (2-flop synchronised)
//   dev_nint  interrupt to host, active low
// Registers (bus.a):
//   0 R  [31:24] head byte, [23] head cmd flag; 0 when empty
//   1 R  [24] not empty, [25] ovf, [26] ferr   W [24] pop, [25] clr ovf, [26] clr ferr
//   2 R  [24] TX idle                          W start TX of d[31:24] when idle
//   3 R  [24] dev_nint                         W dev_nint <= ~d[24]
//   4-7 read 0, writes ignored
// Optional feature macro: CH375_DEV_AUTONINT_EN -- pushing command frame 0x22
//   (GET_STATUS) also releases dev_nint; a same-cycle reg-3 write wins.
module ch375_dev_uart #(
   parameter int unsigned CLOCK_FREQ = 0,
   parameter int unsigned BAUD_RATE  = 0,
   parameter int unsigned RX_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   ch375_dev_uart_if.slave        bus,
   output logic                   dev_tx,
   input  logic                   dev_rx,
   output logic                   dev_nint
);

   localparam int unsigned DIV_CALC = CLOCK_FREQ / (16 * ((BAUD_RATE == 0) ? 1 : BAUD_RATE));
   localparam int unsigned DIV      = (DIV_CALC == 0) ? 1 : DIV_CALC;
   localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PTR_W    = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam logic [7:0]  GET_STATUS = 8'h22;

   typedef struct packed {
      logic       cmd;
      logic [7:0] data;
   } rx_entry_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_FLAG, TX_STOP
   } tx_state_t;

   // ---------------------------------------------------------------- tick divider
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_c;

   assign tick_c = (div_q == DIV_W'(DIV - 1));

   always_comb begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
   end

   // ---------------------------------------------------------------- rx synchroniser
   logic rx_meta_q, rx_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= dev_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------- bus decode
   logic [CNT_W-1:0] count_q;
   logic             not_empty_c, full_c;
   logic             pop_c, clr_ovf_c, clr_ferr_c, tx_start_c, nint_wr_c;
   tx_state_t        tx_state_q;
   logic             unused_d;

   assign not_empty_c = (count_q != '0);
   assign full_c      = (count_q == CNT_W'(RX_DEPTH));
   assign pop_c       = bus.we && (bus.a == 3'd1) && bus.d[24] && not_empty_c;
   assign clr_ovf_c   = bus.we && (bus.a == 3'd1) && bus.d[25];
   assign clr_ferr_c  = bus.we && (bus.a == 3'd1) && bus.d[26];
   assign tx_start_c  = bus.we && (bus.a == 3'd2) && (tx_state_q == TX_IDLE);
   assign nint_wr_c   = bus.we && (bus.a == 3'd3);
   assign unused_d    = ^bus.d[23:0];

   // ---------------------------------------------------------------- RX FSM
   rx_state_t  rx_state_q;
   logic [3:0] rx_tick_q;
   logic [3:0] rx_bit_q;
   logic [8:0] rx_shift_q;
   logic       stop_sample_c, frame_push_c, frame_err_c;

   // Stop bit is sampled on the 16th tick after the flag-bit sample (mid bit).
   assign stop_sample_c = (rx_state_q == RX_STOP) && tick_c && (rx_tick_q == 4'd15);
   assign frame_push_c  = stop_sample_c && rx_sync_q;
   assign frame_err_c   = stop_sample_c && !rx_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_tick_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else if (tick_c) begin
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_sync_q) begin
                  rx_state_q <= RX_START;
                  rx_tick_q  <= '0;
               end
            end
            // Re-check the start bit half a bit in; anything shorter is a glitch.
            RX_START: begin
               if (rx_tick_q == 4'd7) begin
                  rx_tick_q  <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tick_q <= rx_tick_q + 4'd1;
               end
            end
            // Shift in from the top so bit 0 ends at [0] and the flag at [8].
            RX_DATA: begin
               if (rx_tick_q == 4'd15) begin
                  rx_tick_q  <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[8:1]};
                  if (rx_bit_q == 4'd8) rx_state_q <= RX_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 4'd1;
               end else begin
                  rx_tick_q <= rx_tick_q + 4'd1;
               end
            end
            RX_STOP: begin
               if (rx_tick_q == 4'd15) begin
                  rx_tick_q  <= '0;
                  rx_state_q <= RX_WAIT;
               end else begin
                  rx_tick_q <= rx_tick_q + 4'd1;
               end
            end
            RX_WAIT: begin
               if (rx_sync_q) rx_state_q <= RX_IDLE;
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   rx_entry_t        mem_q [RX_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic             push_ok_c;
   rx_entry_t        frame_c, head_c;

   assign push_ok_c = frame_push_c && (!full_c || pop_c);
   assign frame_c   = '{cmd: rx_shift_q[8], data: rx_shift_q[7:0]};
   assign head_c    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= frame_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_ok_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- status, irq, nint
   logic ovf_q, ferr_q, irq_q, dev_nint_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
         irq_q      <= 1'b0;
         dev_nint_q <= 1'b1;
      end else begin
         irq_q <= push_ok_c;
         // A new error in the clearing cycle stays visible.
         if (frame_push_c && !push_ok_c) ovf_q <= 1'b1;
         else if (clr_ovf_c)             ovf_q <= 1'b0;
         if (frame_err_c)                ferr_q <= 1'b1;
         else if (clr_ferr_c)            ferr_q <= 1'b0;
         if (nint_wr_c) dev_nint_q <= ~bus.d[24];
`ifdef CH375_DEV_AUTONINT_EN
         else if (push_ok_c && frame_c.cmd && (frame_c.data == GET_STATUS))
            dev_nint_q <= 1'b1;
`endif
      end
   end

   // ---------------------------------------------------------------- TX FSM
   logic [3:0] tx_tick_q;
   logic [2:0] tx_bit_q;
   logic [7:0] tx_shift_q;
   logic       dev_tx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         dev_tx_q   <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_start_c) begin
                  tx_shift_q <= bus.d[31:24];
                  tx_state_q <= TX_WAIT;
               end
            end
            // Hold off until the next tick so every bit spans exactly 16 ticks.
            TX_WAIT: begin
               if (tick_c) begin
                  dev_tx_q   <= 1'b0;
                  tx_tick_q  <= '0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START, TX_DATA, TX_FLAG, TX_STOP: begin
               if (tick_c) begin
                  if (tx_tick_q == 4'd15) begin
                     tx_tick_q <= '0;
                     case (tx_state_q)
                        TX_START: begin
                           dev_tx_q   <= tx_shift_q[0];
                           tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                           tx_bit_q   <= '0;
                           tx_state_q <= TX_DATA;
                        end
                        TX_DATA: begin
                           if (tx_bit_q == 3'd7) begin
                              dev_tx_q   <= 1'b1;
                              tx_state_q <= TX_FLAG;
                           end else begin
                              dev_tx_q   <= tx_shift_q[0];
                              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                              tx_bit_q   <= tx_bit_q + 3'd1;
                           end
                        end
                        TX_FLAG: begin
                           dev_tx_q   <= 1'b1;
                           tx_state_q <= TX_STOP;
                        end
                        default: tx_state_q <= TX_IDLE;
                     endcase
                  end else begin
                     tx_tick_q <= tx_tick_q + 4'd1;
                  end
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- read mux
   logic [31:0] spo_c;

   always_comb begin
      spo_c = '0;
      case (bus.a)
         3'd0: begin
            if (not_empty_c) begin
               spo_c[31:24] = head_c.data;
               spo_c[23]    = head_c.cmd;
            end
         end
         3'd1: begin
            spo_c[24] = not_empty_c;
            spo_c[25] = ovf_q;
            spo_c[26] = ferr_q;
         end
         3'd2:    spo_c[24] = (tx_state_q == TX_IDLE);
         3'd3:    spo_c[24] = dev_nint_q;
         default: spo_c = '0;
      endcase
   end

   assign bus.spo  = spo_c;
   assign bus.irq  = irq_q;
   assign dev_tx   = dev_tx_q;
   assign dev_nint = dev_nint_q;

endmodule
